// File: rtl/dot_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
//   Shared constants, types and small helpers for the pellet field.
//   COLS x ROWS tiles of TILE_W x TILE_W pixels; one map word per tile row,
//   one bit per tile column (bit c = column c).
// -----------------------------------------------------------------------------
package dot_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int TILE_W = 16;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    EAT_RD,
    EAT_WR
  } state_t;

  typedef logic [5:0]      tile_col_t;
  typedef logic [4:0]      tile_row_t;
  typedef logic [COLS-1:0] map_row_t;

  // Pellets on a freshly filled field: every tile except the outer ring.
  localparam logic [10:0] INIT_COUNT = 11'((ROWS - 2) * (COLS - 2));

  // Range limits in the same widths as the coordinates they are compared to.
  localparam tile_col_t COL_LIMIT = tile_col_t'(COLS);
  localparam tile_row_t ROW_LIMIT = tile_row_t'(ROWS);
  localparam tile_row_t LAST_ROW  = tile_row_t'(ROWS - 1);

  // Fill pattern for one row: empty top/bottom rows, empty first/last column.
  function automatic map_row_t init_row(input tile_row_t r);
    if (r == '0 || r == LAST_ROW) return '0;
    return {1'b0, {(COLS - 2){1'b1}}, 1'b0};
  endfunction

  // Bit `col` of a map row; columns past COLS read as empty.
  function automatic logic row_bit(input map_row_t row, input tile_col_t col);
    logic [63:0] padded;
    padded = {{(64 - COLS){1'b0}}, row};
    return padded[col];
  endfunction

  // Map row with bit `col` cleared (no effect for columns past COLS).
  function automatic map_row_t clear_bit(input map_row_t row, input tile_col_t col);
    logic [63:0] mask;
    mask = 64'd1 << col;
    return row & ~mask[COLS-1:0];
  endfunction

endpackage

// File: rtl/dot_sprite_rom.sv
// -----------------------------------------------------------------------------
// dot_sprite_rom
//   16x16 pellet sprite, one 16-bit word per sprite row; bit 15 is the
//   leftmost pixel. Synchronous read: data follows addr by one clock.
//   Ports: clk, addr[5:0] (sprite row; upper bits select unused sprites),
//          data[15:0] (registered row bits).
// -----------------------------------------------------------------------------
module dot_sprite_rom (
  input  logic        clk,
  input  logic [5:0]  addr,
  output logic [15:0] data
);

  // Pellet is a small diamond centred in the tile: rows 6..8.
  always_ff @(posedge clk) begin
    case (addr)
      6'd6, 6'd8: data <= 16'h0180;
      6'd7:       data <= 16'h03C0;
      default:    data <= 16'h0000;
    endcase
  end

endmodule

// File: rtl/pellet_map_ram.sv
// -----------------------------------------------------------------------------
// pellet_map_ram
//   ROWS x COLS pellet occupancy map, one read port and one write port.
//   The read is registered; a read and a write to the same row in one cycle
//   return the row as it was before the write.
//   Ports: clk, rst_n (async, active-low; clears the map),
//          rd_row / rd_data (read address / registered row, zero if out of range),
//          wr_en / wr_row / wr_data (write port; out-of-range rows ignored).
// -----------------------------------------------------------------------------
module pellet_map_ram
  import dot_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_row,
  input  logic [COLS-1:0] wr_data
);

  map_row_t mem [ROWS];

  // NOTE: the map must read as empty straight out of reset, so the storage is
  // built from resettable flops instead of a RAM macro without a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && (wr_row < ROW_LIMIT)) mem[wr_row] <= wr_data;
      // Samples the pre-write contents, giving read-before-write ordering.
      rd_data <= (rd_row < ROW_LIMIT) ? mem[rd_row] : '0;
    end
  end

endmodule

// File: rtl/dot_field_ctrl.sv
// -----------------------------------------------------------------------------
// dot_field_ctrl
//   Owns the pellet field: keeps the tile occupancy map, renders the per-pixel
//   dot_on stream (2-cycle latency), serves pellet "eat" requests through the
//   shared map read port, counts remaining pellets and flags level clear.
//
//   Ports:
//     Clk, Reset_n       clock, asynchronous active-low reset
//     init_req           one-cycle pulse: refill the field
//     pix_valid          DrawX/DrawY is an active-area pixel this cycle
//     DrawX, DrawY       pixel coordinates (10 bits each)
//     dot_on             pellet pixel lit for the pixel of 2 cycles earlier
//     eat_req            eat request, held until eat_ack
//     eat_col, eat_row   tile to eat, stable while eat_req=1
//     eat_ack            one-cycle completion pulse
//     eat_hit            with eat_ack: a pellet was there and is now gone
//     remaining          pellets left
//     level_clear        one-cycle pulse when remaining drops to 0
//     busy               high while the field is being refilled
// -----------------------------------------------------------------------------
module dot_field_ctrl
  import dot_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        init_req,
  input  logic        pix_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        dot_on,
  input  logic        eat_req,
  input  logic [5:0]  eat_col,
  input  logic [4:0]  eat_row,
  output logic        eat_ack,
  output logic        eat_hit,
  output logic [10:0] remaining,
  output logic        level_clear,
  output logic        busy
);

  state_t    state;
  tile_row_t init_r;

  // Render pipeline, stage S1 registers.
  logic      pv_s1;
  tile_col_t col_s1;
  logic      row_oob_s1;
  logic [3:0] subx_s1;

  // Map and sprite ROM ports.
  tile_row_t map_rd_row;
  map_row_t  map_rd_data;
  logic      map_we;
  tile_row_t map_wr_row;
  map_row_t  map_wr_data;
  logic [15:0] rom_data;

  logic render_on;
  logic enter_init;
  logic eat_oob;
  logic eat_commit;
  logic old_bit;
  logic occ_s1;
  logic sprite_bit;

  assign render_on  = (state != INIT);
  assign enter_init = init_req && (state != INIT);
  assign eat_oob    = (eat_col >= COL_LIMIT) || (eat_row >= ROW_LIMIT);

  // An eat completes in EAT_WR unless a refill request aborts it that cycle,
  // so the handshake outputs are decoded from the state and the map row that
  // was read in EAT_RD (held in the RAM output register).
  assign eat_commit  = (state == EAT_WR) && !init_req;
  assign old_bit     = !eat_oob && row_bit(map_rd_data, eat_col);
  assign eat_ack     = eat_commit;
  assign eat_hit     = eat_commit && old_bit;
  assign level_clear = eat_commit && old_bit && (remaining == 11'd1);
  assign busy        = (state == INIT);

  // Shared read port: the render stream owns it whenever a pixel is valid;
  // otherwise it is offered to the eat path.
  assign map_rd_row = pix_valid ? DrawY[8:4] : eat_row;

  assign occ_s1     = !row_oob_s1 && (col_s1 < COL_LIMIT) && row_bit(map_rd_data, col_s1);
  assign sprite_bit = rom_data[4'd15 - subx_s1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    map_we      = 1'b0;
    map_wr_row  = eat_row;
    map_wr_data = clear_bit(map_rd_data, eat_col);
    if (state == INIT) begin
      map_we      = 1'b1;
      map_wr_row  = init_r;
      map_wr_data = init_row(init_r);
    end else if (eat_commit && !eat_oob) begin
      map_we = 1'b1;
    end
  end

  pellet_map_ram u_map (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .rd_row  (map_rd_row),
    .rd_data (map_rd_data),
    .wr_en   (map_we),
    .wr_row  (map_wr_row),
    .wr_data (map_wr_data)
  );

  dot_sprite_rom u_rom (
    .clk  (Clk),
    .addr ({2'b00, DrawY[3:0]}),
    .data (rom_data)
  );

  // Render pipeline: S0 captures the pixel and issues map/ROM reads; S1 picks
  // the tile bit and sprite bit and registers dot_on.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pv_s1      <= 1'b0;
      col_s1     <= '0;
      row_oob_s1 <= 1'b0;
      subx_s1    <= '0;
      dot_on     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the pre-edge values of the others, whatever the statement order.
      pv_s1      <= pix_valid && render_on;
      col_s1     <= DrawX[9:4];
      row_oob_s1 <= DrawY[9] || (DrawY[8:4] >= ROW_LIMIT);
      subx_s1    <= DrawX[3:0];
      // Cleared on the edge into INIT as well, so dot_on is low for the whole
      // refill rather than showing one stale pixel.
      dot_on     <= render_on && !enter_init && pv_s1 && occ_s1 && sprite_bit;
    end
  end

  // Control FSM: refill sweep, eat read/modify/write, pellet counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= INIT;
      init_r    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        INIT: begin
          // Refill requests during the sweep are ignored; it runs to the end.
          if (init_r == LAST_ROW) begin
            state     <= IDLE;
            init_r    <= '0;
            remaining <= INIT_COUNT;
          end else begin
            init_r <= init_r + 5'd1;
          end
        end
        IDLE: begin
          if (init_req) begin
            state  <= INIT;
            init_r <= '0;
          end else if (eat_req) begin
            state <= EAT_RD;
          end
        end
        EAT_RD: begin
          if (init_req) begin
            state  <= INIT;
            init_r <= '0;
          end else if (!pix_valid) begin
            state <= EAT_WR;
          end
        end
        EAT_WR: begin
          if (init_req) begin
            state  <= INIT;
            init_r <= '0;
          end else begin
            // A hit implies a pellet is counted, so this never underflows;
            // the zero guard only keeps the counter safe against a corrupt map.
            if (old_bit && (remaining != 11'd0)) remaining <= remaining - 11'd1;
            state <= IDLE;
          end
        end
        default: begin
          state  <= INIT;
          init_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_field_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dot_field_ctrl
//   Directed bench for dot_field_ctrl. Inputs change 1 time unit after the
//   rising edge; outputs are sampled 1 unit later. dot_on is compared every
//   cycle against a pellet map kept by the bench and a hand-written sprite.
// -----------------------------------------------------------------------------
module tb_dot_field_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        init_req;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        dot_on;
  logic        eat_req;
  logic [5:0]  eat_col;
  logic [4:0]  eat_row;
  logic        eat_ack;
  logic        eat_hit;
  logic [10:0] remaining;
  logic        level_clear;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Sampled outputs of the current cycle.
  logic s_ack, s_hit, s_lc, s_busy, s_dot;
  int   s_rem;

  // Expected dot_on for the pixels of 1 and 2 cycles ago.
  logic exp_p1 = 1'b0;
  logic exp_p2 = 1'b0;
  int   render_err = 0;
  int   lit_cnt = 0;

  logic model_map [30][40];

  dot_field_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .init_req    (init_req),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .dot_on      (dot_on),
    .eat_req     (eat_req),
    .eat_col     (eat_col),
    .eat_row     (eat_row),
    .eat_ack     (eat_ack),
    .eat_hit     (eat_hit),
    .remaining   (remaining),
    .level_clear (level_clear),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // 16x16 pellet: rows 6 and 8 lit at x 7..8, row 7 lit at x 6..9.
  function automatic logic sprite_px(input int sx, input int sy);
    return ((sy == 6 || sy == 8) && (sx == 7 || sx == 8)) ||
           (sy == 7 && sx >= 6 && sx <= 9);
  endfunction

  function automatic logic exp_pixel(input int x, input int y);
    int tc = x / 16;
    int tr = y / 16;
    if (tc >= 40 || tr >= 30) return 1'b0;
    return model_map[tr][tc] && sprite_px(x % 16, y % 16);
  endfunction

  task automatic model_fill();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        model_map[r][c] = (r > 0 && r < 29 && c > 0 && c < 39);
  endtask

  // Called with this cycle's inputs already applied; samples, then advances.
  task automatic step();
    #1;
    s_ack  = eat_ack;
    s_hit  = eat_hit;
    s_lc   = level_clear;
    s_busy = busy;
    s_dot  = dot_on;
    s_rem  = int'(remaining);
    if (s_dot !== exp_p2) render_err++;
    if (s_dot) lit_cnt++;
    exp_p2 = exp_p1;
    exp_p1 = pix_valid ? exp_pixel(int'(DrawX), int'(DrawY)) : 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic render_tile(input string tag, input int cx, input int cy, input int exp_lit);
    render_err = 0;
    lit_cnt = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        pix_valid = 1'b1;
        DrawX = 10'(cx * 16 + x);
        DrawY = 10'(cy * 16 + y);
        step();
      end
    pix_valid = 1'b0;
    step();
    step();
    check({tag, "_pixel_mismatches"}, render_err, 0);
    check({tag, "_lit_pixels"}, lit_cnt, exp_lit);
  endtask

  // Raises eat_req, waits for the ack (bounded), drops it and runs one more
  // cycle so `remaining` shows the update. lat = cycles from request to ack.
  task automatic do_eat(input int col, input int row, input int budget,
                        output int lat, output int hit, output int lc);
    lat = -1;
    hit = 0;
    lc  = 0;
    eat_col = 6'(col);
    eat_row = 5'(row);
    eat_req = 1'b1;
    for (int i = 0; i < budget && lat < 0; i++) begin
      step();
      if (s_ack) begin
        lat = i;
        hit = int'(s_hit);
        lc  = int'(s_lc);
      end
    end
    eat_req = 1'b0;
    step();
    if (lat >= 0 && col < 40 && row < 30) model_map[row][col] = 1'b0;
  endtask

  // Releases reset and follows the refill sweep.
  task automatic release_and_wait(input string tag);
    int busy_n = 0;
    int first_low = -1;
    int acks = 0;
    Reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (s_busy) begin
        busy_n++;
        if (s_ack) acks++;
      end else if (first_low < 0) begin
        first_low = i;
      end
    end
    check({tag, "_busy_cycles"}, busy_n, 30);
    check({tag, "_busy_fall_cycle"}, first_low, 30);
    check({tag, "_ack_during_init"}, acks, 0);
    eat_req = 1'b0;
    repeat (4) step();
    check({tag, "_remaining"}, s_rem, 1064);
    check({tag, "_busy_after"}, int'(s_busy), 0);
    model_fill();
  endtask

  initial begin
    int lat, hit, lc, busy_n, rem_at_ack, acks, exp_rem, mism, lc_cnt, lc_last, ack_f;
    logic exp_hit;

    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        model_map[r][c] = 1'b0;
    Reset_n   = 1'b0;
    init_req  = 1'b0;
    pix_valid = 1'b0;
    DrawX     = '0;
    DrawY     = '0;
    eat_req   = 1'b0;
    eat_col   = '0;
    eat_row   = '0;
    @(posedge Clk);
    #1;

    // Reset values.
    step();
    check("rst_dot_on", int'(s_dot), 0);
    check("rst_eat_ack", int'(s_ack), 0);
    check("rst_eat_hit", int'(s_hit), 0);
    check("rst_level_clear", int'(s_lc), 0);
    check("rst_remaining", s_rem, 0);
    check("rst_busy", int'(s_busy), 1);

    // Release with an (out-of-range) eat held through the sweep.
    eat_req = 1'b1;
    eat_col = 6'd45;
    eat_row = 5'd31;
    release_and_wait("init1");

    // Render a pellet tile and a border tile.
    render_tile("render_5_7", 5, 7, 8);
    render_tile("render_0_0", 0, 0, 0);

    // Eat (5,7) during blanking, re-render, eat again.
    do_eat(5, 7, 10, lat, hit, lc);
    check("eat_5_7_latency", lat, 2);
    check("eat_5_7_hit", hit, 1);
    check("eat_5_7_remaining", s_rem, 1063);
    render_tile("render_5_7_eaten", 5, 7, 0);
    do_eat(5, 7, 10, lat, hit, lc);
    check("reeat_5_7_latency", lat, 2);
    check("reeat_5_7_hit", hit, 0);
    check("reeat_5_7_remaining", s_rem, 1063);

    // Arbitration: eat (20,15) held while 100 pixels of tile (6,7) stream.
    render_err = 0;
    lit_cnt = 0;
    acks = 0;
    eat_col = 6'd20;
    eat_row = 5'd15;
    eat_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pix_valid = 1'b1;
      DrawX = 10'(96 + i % 16);
      DrawY = 10'(116 + i / 16);
      step();
      if (s_ack) acks++;
    end
    check("arb_ack_while_pix_valid", acks, 0);
    pix_valid = 1'b0;
    step();
    ack_f = int'(s_ack);
    check("arb_ack_first_blank_cycle", ack_f, 0);
    step();
    check("arb_ack_second_blank_cycle", int'(s_ack), 1);
    check("arb_hit", int'(s_hit), 1);
    eat_req = 1'b0;
    step();
    model_map[15][20] = 1'b0;
    check("arb_remaining", s_rem, 1062);
    check("arb_render_mismatches", render_err, 0);
    check("arb_render_lit", lit_cnt, 8);

    // Out-of-range eat.
    do_eat(45, 31, 10, lat, hit, lc);
    check("oob_latency", lat, 2);
    check("oob_hit", hit, 0);
    check("oob_remaining", s_rem, 1062);

    // Refill request while an eat sits in EAT_RD.
    eat_col = 6'd10;
    eat_row = 5'd10;
    eat_req = 1'b1;
    step();
    init_req = 1'b1;
    step();
    check("abort_ack_in_eat_rd", int'(s_ack), 0);
    init_req = 1'b0;
    lat = -1;
    hit = 0;
    busy_n = 0;
    rem_at_ack = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      step();
      if (s_busy) busy_n++;
      if (s_ack) begin
        lat = i;
        hit = int'(s_hit);
        rem_at_ack = s_rem;
      end
    end
    eat_req = 1'b0;
    step();
    model_fill();
    model_map[10][10] = 1'b0;
    check("abort_init_busy_cycles", busy_n, 30);
    check("abort_served_latency", lat, 32);
    check("abort_served_hit", hit, 1);
    check("abort_remaining_at_ack", rem_at_ack, 1064);
    check("abort_remaining_after", s_rem, 1063);

    // Async reset in the middle of EAT_WR.
    eat_col = 6'd5;
    eat_row = 5'd5;
    eat_req = 1'b1;
    step();
    step();
    Reset_n = 1'b0;
    step();
    check("midrst_eat_ack", int'(s_ack), 0);
    check("midrst_eat_hit", int'(s_hit), 0);
    check("midrst_level_clear", int'(s_lc), 0);
    check("midrst_remaining", s_rem, 0);
    check("midrst_busy", int'(s_busy), 1);
    check("midrst_dot_on", int'(s_dot), 0);
    eat_req = 1'b0;
    step();
    release_and_wait("init2");

    // Eat the whole field.
    exp_rem = 1064;
    mism = 0;
    lc_cnt = 0;
    lc_last = 0;
    for (int r = 1; r < 29; r++)
      for (int c = 1; c < 39; c++) begin
        exp_hit = model_map[r][c];
        do_eat(c, r, 10, lat, hit, lc);
        if (exp_hit) exp_rem--;
        if (lat != 2 || hit != int'(exp_hit) || s_rem != exp_rem) mism++;
        if (lc != 0) begin
          lc_cnt++;
          lc_last = (r == 28 && c == 38) ? 1 : 0;
        end
      end
    check("clear_eat_mismatches", mism, 0);
    check("clear_level_clear_pulses", lc_cnt, 1);
    check("clear_on_last_ack", lc_last, 1);
    check("clear_remaining", s_rem, 0);
    render_tile("render_after_clear", 5, 7, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dot_field_ctrl.md
Name: dot_field_ctrl

Overview:
- Owns the pellet field of the playfield.
- Keeps a per-tile pellet occupancy map (40x30 tiles of 16x16 px).
- Sequences the shared dot sprite ROM and the map read port to produce a per-pixel dot_on for the colour mapper.
- Arbitrates the same map port with "eat" requests from the player logic, counts remaining pellets, and signals level clear.

Parameters:
- COLS, 40, tiles per row.
- ROWS, 30, tile rows.
- TILE_W, 16, tile/sprite size in px; fixed to the 16x16 dot sprite.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- init_req  in  1  one-cycle pulse: refill the field
- pix_valid  in  1  DrawX/DrawY is an active-area pixel this cycle
- DrawX  in  10  pixel column
- DrawY  in  10  pixel row
- dot_on  out  1  pellet pixel lit; matches the pixel presented 2 cycles earlier
- eat_req  in  1  player requests pellet removal; held until eat_ack
- eat_col  in  6  tile column; stable while eat_req=1
- eat_row  in  5  tile row; stable while eat_req=1
- eat_ack  out  1  one-cycle completion pulse
- eat_hit  out  1  valid with eat_ack: a pellet was present and was removed
- remaining  out  11  pellets left in the field
- level_clear  out  1  one-cycle pulse when remaining reaches 0
- busy  out  1  high in INIT

Behaviour:
- Reset (async, Reset_n=0) values:
  - map all 0; state INIT with row counter 0
  - dot_on=0, eat_ack=0, eat_hit=0, level_clear=0, remaining=0, busy=1
- Map storage:
  - ROWS words of COLS bits.
  - One shared read port, one write port.
  - A read and a write to the same row in the same cycle return the old data.
- Render pipeline (latency 2), active in every state except INIT:
  - S0: register pix_valid, tile col = DrawX[9:4], tile row = DrawY[9:4], sub-x = DrawX[3:0].
  - Drive dot ROM addr = {2'b00, DrawY[3:0]}.
  - S1: read the map row; occ = row[col], forced to 0 if col>=COLS or row>=ROWS.
  - Sprite bit = rom_data[15 - subx].
  - dot_on register <= pix_valid_d & occ & sprite bit.
  - In INIT, dot_on is forced to 0.
- FSM: INIT, IDLE, EAT_RD, EAT_WR.
  - INIT:
    - Writes row r each cycle: all ones except bits 0 and COLS-1; rows 0 and ROWS-1 written all zero.
    - r increments by 1 per cycle; after writing ROWS-1 (ROWS cycles total), go to IDLE.
    - remaining <= (ROWS-2)*(COLS-2) = 1064 on the exit cycle.
    - busy=1. eat_req is not served. init_req is ignored (the sweep does not restart).
  - IDLE: init_req -> INIT (r=0); else eat_req -> EAT_RD.
  - EAT_RD:
    - The render read has priority: if pix_valid=1, stall in EAT_RD.
    - If pix_valid=0, read row eat_row and latch it, then go to EAT_WR.
    - Out-of-range coordinates latch an empty row.
  - EAT_WR:
    - Write the latched row with bit eat_col cleared; out-of-range coordinates write nothing.
    - Assert eat_ack=1; eat_hit = old bit.
    - If hit, remaining decrements by 1; on the 1->0 transition, level_clear=1 for that cycle.
    - Return to IDLE. A still-high eat_req in IDLE is served again, giving hit=0.
  - init_req in EAT_RD or EAT_WR:
    - Go to INIT next cycle.
    - The pending eat is aborted with no ack and no write; the requester keeps eat_req and is served after INIT.
- Arithmetic and edge cases:
  - remaining never underflows; decrement is only possible on a hit, and a hit requires remaining>0.
  - The map is not cleared on level_clear.

Decomposition:
- Package dot_pkg:
  - COLS, ROWS, TILE_W, INIT_COUNT=1064.
  - Typedef state_t enum {INIT, IDLE, EAT_RD, EAT_WR}.
  - Typedefs tile_col_t [5:0], tile_row_t [4:0].
- Sub-modules:
  - Instantiate the existing dot sprite ROM (6-bit addr, 16-bit data).
  - Natural new sub-module: pellet_map_ram (ROWS x COLS, 1R1W, read-before-write).

Test Plan:
- Reset then release:
  - busy=1 for exactly 30 cycles after reset release; then busy=0 and remaining=1064.
  - No eat_ack during INIT even with eat_req held.
- Render tile (5,7):
  - Sweep DrawX=80..95, DrawY=112..127 with pix_valid=1.
  - dot_on=1 exactly 2 cycles after the pixels with DrawY[3:0] in {6,8}, DrawX[3:0] in {7,8}.
  - Same for DrawY[3:0]=7 with DrawX[3:0] in 6..9; 0 elsewhere.
  - Border tile (0,0) always 0.
- Eat (5,7) during blanking:
  - eat_ack in the 2nd cycle after the request, eat_hit=1, remaining=1063.
  - Re-render of the tile gives all-zero dot_on.
  - Repeat eat -> hit=0, remaining unchanged.
- Arbitration:
  - eat_req while pix_valid=1 for 100 cycles -> no ack during those cycles.
  - Ack 2 cycles after pix_valid falls.
  - Render output is uninterrupted and correct throughout.
- Out-of-range eat (col=45, row=31): ack with hit=0, remaining unchanged.
- Level clear and init:
  - Eat all 1064 pellets -> level_clear pulses once on the last ack; remaining=0.
  - init_req during EAT_RD -> no ack, INIT runs, remaining=1064, then the held eat is served with hit=1.
- Async reset mid-EAT_WR: all outputs return to reset values immediately; INIT restarts after release.
